// File: rtl/note_draw_pkg.sv
// -----------------------------------------------------------------------------
// note_draw_pkg
// Shared definitions for the note-drawing controller:
//   - default grid and box-count values used as parameter defaults
//   - the controller state encoding
// -----------------------------------------------------------------------------
package note_draw_pkg;

  localparam int DEF_GRID_W    = 240;
  localparam int DEF_GRID_H    = 180;
  localparam int DEF_NUM_BOXES = 12;

  // Encodings 10..15 are unused and recover to ST_RESET.
  typedef enum logic [3:0] {
    ST_RESET      = 4'd0,
    ST_CLR_LOAD   = 4'd1,
    ST_CLR_WRITE  = 4'd2,
    ST_START      = 4'd3,
    ST_START_WAIT = 4'd4,
    ST_WAIT_SONG  = 4'd5,
    ST_SELECT     = 4'd6,
    ST_LOAD_BOX   = 4'd7,
    ST_DRAW       = 4'd8,
    ST_WAIT_SHAPE = 4'd9
  } state_e;

endpackage

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Up-counter with synchronous reset, synchronous clear and count enable.
// Clear has priority over enable.
//   clock_i   in   clock
//   reset_i   in   synchronous active-high reset, forces count to 0
//   clear_i   in   synchronous clear to 0
//   enable_i  in   increment by one
//   count_o   out  current count
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/note_draw_fsm.sv
// -----------------------------------------------------------------------------
// note_draw_fsm
// Moore controller that clears a pixel grid and then, on every beat, walks the
// note boxes and hands each enabled box to an external shape drawer.
//
// Ports
//   clock                  in   system clock, rising edge
//   reset                  in   synchronous active-high reset
//   start                  in   start-song button (level, press-and-release)
//   beatIncremented        in   one-cycle beat strobe
//   songDone               in   song finished (level)
//   shapeDone              in   one-cycle strobe from the shape drawer
//   boxActive              in   per-box enable mask, sampled in SELECT
//   loadDefault            out  load background pixel
//   writeDefault           out  write background pixel at gridCounter
//   readyForSong           out  idle and waiting for a beat
//   loadStartAddress       out  load start address of box boxIndex
//   startingAddressLoaded  out  kick the shape drawer for box boxIndex
//   gridCounter            out  clear pixel address
//   boxIndex               out  current box
//   beatOverrun            out  sticky: a beat arrived while busy
// -----------------------------------------------------------------------------
module note_draw_fsm
  import note_draw_pkg::*;
#(
  parameter int GRID_W          = DEF_GRID_W,
  parameter int GRID_H          = DEF_GRID_H,
  parameter int NUM_BOXES       = DEF_NUM_BOXES,
  parameter int CLEAR_EACH_BEAT = 0,
  localparam int GRID_N         = GRID_W * GRID_H,
  localparam int GW             = (GRID_N > 1) ? $clog2(GRID_N) : 1,
  localparam int BW             = $clog2(NUM_BOXES + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 beatIncremented,
  input  logic                 songDone,
  input  logic                 shapeDone,
  input  logic [NUM_BOXES-1:0] boxActive,
  output logic                 loadDefault,
  output logic                 writeDefault,
  output logic                 readyForSong,
  output logic                 loadStartAddress,
  output logic                 startingAddressLoaded,
  output logic [GW-1:0]        gridCounter,
  output logic [BW-1:0]        boxIndex,
  output logic                 beatOverrun
);

  localparam logic [GW-1:0] GRID_LAST = GW'(GRID_N - 1);
  localparam logic [BW-1:0] BOX_END   = BW'(NUM_BOXES);
  // boxIndex can reach NUM_BOXES, so the mask is zero-padded to the full
  // index range to keep the select in bounds.
  localparam int            PAD_W     = 2 ** BW;

  state_e state_q, state_d;
  // Remembers whether the clear in progress was started by a beat (exit to
  // SELECT) or by reset/songDone (exit to START).
  logic   beat_clear_q, beat_clear_d;
  logic   beat_overrun_q, beat_overrun_d;

  logic   grid_clr, grid_en;
  logic   box_clr, box_en;

  logic [PAD_W-1:0] active_pad;
  assign active_pad = {{(PAD_W - NUM_BOXES){1'b0}}, boxActive};

  mod_counter #(.WIDTH(GW)) u_grid_cnt (
    .clock_i  (clock),
    .reset_i  (reset),
    .clear_i  (grid_clr),
    .enable_i (grid_en),
    .count_o  (gridCounter)
  );

  mod_counter #(.WIDTH(BW)) u_box_cnt (
    .clock_i  (clock),
    .reset_i  (reset),
    .clear_i  (box_clr),
    .enable_i (box_en),
    .count_o  (boxIndex)
  );

  always_comb begin
    state_d               = state_q;
    beat_clear_d          = beat_clear_q;
    grid_clr              = 1'b0;
    grid_en               = 1'b0;
    box_clr               = 1'b0;
    box_en                = 1'b0;
    loadDefault           = 1'b0;
    writeDefault          = 1'b0;
    readyForSong          = 1'b0;
    loadStartAddress      = 1'b0;
    startingAddressLoaded = 1'b0;

    unique case (state_q)
      ST_RESET: begin
        beat_clear_d = 1'b0;
        state_d      = ST_CLR_LOAD;
      end
      ST_CLR_LOAD: begin
        loadDefault = 1'b1;
        state_d     = ST_CLR_WRITE;
      end
      ST_CLR_WRITE: begin
        writeDefault = 1'b1;
        if (gridCounter == GRID_LAST) begin
          grid_clr = 1'b1;
          state_d  = beat_clear_q ? ST_SELECT : ST_START;
        end else begin
          grid_en = 1'b1;
          state_d = ST_CLR_LOAD;
        end
      end
      ST_START: begin
        if (start) state_d = ST_START_WAIT;
      end
      ST_START_WAIT: begin
        if (!start) state_d = ST_WAIT_SONG;
      end
      ST_WAIT_SONG: begin
        readyForSong = 1'b1;
        box_clr      = 1'b1;
        if (songDone) begin
          beat_clear_d = 1'b0;
          state_d      = ST_CLR_LOAD;
        end else if (beatIncremented) begin
          if (CLEAR_EACH_BEAT != 0) begin
            beat_clear_d = 1'b1;
            state_d      = ST_CLR_LOAD;
          end else begin
            state_d = ST_SELECT;
          end
        end
      end
      ST_SELECT: begin
        if (boxIndex == BOX_END) begin
          box_clr = 1'b1;
          state_d = ST_WAIT_SONG;
        end else if (active_pad[boxIndex]) begin
          state_d = ST_LOAD_BOX;
        end else begin
          box_en = 1'b1;
        end
      end
      ST_LOAD_BOX: begin
        loadStartAddress = 1'b1;
        state_d          = ST_DRAW;
      end
      ST_DRAW: begin
        startingAddressLoaded = 1'b1;
        state_d               = ST_WAIT_SHAPE;
      end
      ST_WAIT_SHAPE: begin
        if (shapeDone) begin
          box_en  = 1'b1;
          state_d = ST_SELECT;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // A beat is only consumed in WAIT_SONG; START/START_WAIT drop it silently,
  // any other state flags it as an overrun.
  always_comb begin
    beat_overrun_d = beat_overrun_q;
    if (beatIncremented &&
        !(state_q inside {ST_WAIT_SONG, ST_START, ST_START_WAIT})) begin
      beat_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_RESET;
      beat_clear_q   <= 1'b0;
      beat_overrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_clear_q   <= beat_clear_d;
      beat_overrun_q <= beat_overrun_d;
    end
  end

  assign beatOverrun = beat_overrun_q;

endmodule

// File: tb/tb_note_draw_fsm.sv
// -----------------------------------------------------------------------------
// tb_note_draw_fsm
// Two instances on one clock: index 0 without per-beat clear, index 1 with it.
// Stimulus pushes the expected output events (pixel writes, box loads, draw
// kicks, ready edges) into a per-instance queue; a monitor per instance pops
// and compares whenever the design presents one of those outputs.
// -----------------------------------------------------------------------------
module tb_note_draw_fsm;

  localparam int GRID_W    = 4;
  localparam int GRID_H    = 3;
  localparam int GRID_N    = GRID_W * GRID_H;
  localparam int NUM_BOXES = 4;
  localparam int GW        = 4;
  localparam int BW        = 3;

  typedef enum int {EV_WR, EV_LOAD, EV_DRAW, EV_READY} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       val;
  } ev_t;

  ev_t exp_q[2][$];

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset_r[2];
  logic                 start_r[2];
  logic                 beat_r[2];
  logic                 inj_beat[2];
  logic                 song_r[2];
  logic                 shape_r[2];
  logic                 stray_shape[2];
  logic [NUM_BOXES-1:0] act_r[2];

  logic          ld[2], wr[2], rdy[2], lsa[2], sal[2], ovr[2];
  logic [GW-1:0] gc[2];
  logic [BW-1:0] bi[2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit exp_ovr[2];
  bit inj_en[2];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_event(int d, ev_kind_e kind, int val);
    ev_t e;
    if (exp_q[d].size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d unexpected event: got kind %0d value %0d, expected no event",
               d, int'(kind), val);
    end else begin
      e = exp_q[d].pop_front();
      check($sformatf("dut%0d event kind", d), int'(kind), int'(e.kind));
      check($sformatf("dut%0d event value", d), val, e.val);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic beat_in, shape_in;
    logic rdy_prev = 1'b0;
    logic ld_prev  = 1'b0;
    int   last_wr  = -100;

    assign beat_in  = beat_r[g] | inj_beat[g];
    assign shape_in = shape_r[g] | stray_shape[g];

    note_draw_fsm #(
      .GRID_W          (GRID_W),
      .GRID_H          (GRID_H),
      .NUM_BOXES       (NUM_BOXES),
      .CLEAR_EACH_BEAT (g)
    ) u_dut (
      .clock                 (clock),
      .reset                 (reset_r[g]),
      .start                 (start_r[g]),
      .beatIncremented       (beat_in),
      .songDone              (song_r[g]),
      .shapeDone             (shape_in),
      .boxActive             (act_r[g]),
      .loadDefault           (ld[g]),
      .writeDefault          (wr[g]),
      .readyForSong          (rdy[g]),
      .loadStartAddress      (lsa[g]),
      .startingAddressLoaded (sal[g]),
      .gridCounter           (gc[g]),
      .boxIndex              (bi[g]),
      .beatOverrun           (ovr[g])
    );

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clock) begin
      if (reset_r[g]) begin
        rdy_prev <= 1'b0;
        ld_prev  <= 1'b0;
        last_wr  <= -100;
      end else begin
        if (wr[g]) begin
          check_event(g, EV_WR, int'(gc[g]));
          check($sformatf("dut%0d load precedes write", g), int'(ld_prev), 1);
          if (gc[g] != '0)
            check($sformatf("dut%0d write spacing", g), cyc - last_wr, 2);
          last_wr <= cyc;
        end
        if (lsa[g]) check_event(g, EV_LOAD, int'(bi[g]));
        if (sal[g]) check_event(g, EV_DRAW, int'(bi[g]));
        if (rdy[g] && !rdy_prev) check_event(g, EV_READY, 0);
        rdy_prev <= rdy[g];
        ld_prev  <= ld[g];
      end
    end
  end

  // Shape-drawer stand-in: answers each draw kick after 1..4 cycles, and when
  // requested fires a beat alongside shapeDone (always while busy drawing).
  initial begin : responder
    int dly;
    shape_r[0]  = 1'b0;
    shape_r[1]  = 1'b0;
    inj_beat[0] = 1'b0;
    inj_beat[1] = 1'b0;
    forever begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        if (sal[d] === 1'b1 && !reset_r[d]) begin
          dly = $urandom_range(1, 4);
          repeat (dly) @(posedge clock);
          #1;
          shape_r[d]  = 1'b1;
          inj_beat[d] = inj_en[d];
          @(posedge clock);
          #1;
          shape_r[d]  = 1'b0;
          inj_beat[d] = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: expected event streams ----------------
  task automatic push(int d, ev_kind_e k, int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q[d].push_back(e);
  endtask

  task automatic push_clear(int d);
    for (int a = 0; a < GRID_N; a++) push(d, EV_WR, a);
  endtask

  // Instance index doubles as its per-beat-clear setting.
  task automatic push_beat(int d, logic [NUM_BOXES-1:0] m);
    if (d == 1) push_clear(d);
    for (int i = 0; i < NUM_BOXES; i++) begin
      if (m[i]) begin
        push(d, EV_LOAD, i);
        push(d, EV_DRAW, i);
      end
    end
    push(d, EV_READY, 0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(int d, string what);
    int k = 0;
    while (exp_q[d].size() != 0 && k < 400) begin
      @(negedge clock);
      k++;
    end
    check($sformatf("dut%0d %s events outstanding", d, what), exp_q[d].size(), 0);
    exp_q[d].delete();
  endtask

  task automatic start_song(int d);
    repeat (4) tick();
    check($sformatf("dut%0d idle before press", d), int'(rdy[d]), 0);
    push(d, EV_READY, 0);
    start_r[d] = 1'b1;
    repeat (3) tick();
    check($sformatf("dut%0d held while pressed", d), int'(rdy[d]), 0);
    start_r[d] = 1'b0;
    drain(d, "start");
    check($sformatf("dut%0d ready after release", d), int'(rdy[d]), 1);
  endtask

  task automatic issue_beat(int d, logic [NUM_BOXES-1:0] m);
    push_beat(d, m);
    tick();
    act_r[d]  = m;
    beat_r[d] = 1'b1;
    tick();
    beat_r[d] = 1'b0;
  endtask

  task automatic check_ovr(int d);
    check($sformatf("dut%0d beatOverrun", d), int'(ovr[d]), int'(exp_ovr[d]));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [NUM_BOXES-1:0] m;
    int n;
    int k;
    for (int d = 0; d < 2; d++) begin
      reset_r[d]     = 1'b1;
      start_r[d]     = 1'b0;
      beat_r[d]      = 1'b0;
      song_r[d]      = 1'b0;
      stray_shape[d] = 1'b0;
      act_r[d]       = '0;
      exp_ovr[d]     = 1'b0;
      inj_en[d]      = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset gridCounter", d), int'(gc[d]), 0);
      check($sformatf("dut%0d reset boxIndex", d), int'(bi[d]), 0);
      check($sformatf("dut%0d reset beatOverrun", d), int'(ovr[d]), 0);
      check($sformatf("dut%0d reset outputs", d),
            int'({ld[d], wr[d], rdy[d], lsa[d], sal[d]}), 0);
    end

    // Power-on clear on both instances, then start the song.
    push_clear(0);
    push_clear(1);
    reset_r[0] = 1'b0;
    reset_r[1] = 1'b0;
    drain(0, "power-on clear");
    drain(1, "power-on clear");
    start_song(0);
    start_song(1);

    // ---- instance 0: no per-beat clear ----
    issue_beat(0, 4'b1010);
    drain(0, "mask 1010");
    check_ovr(0);

    // Empty mask: back to ready after NUM_BOXES+1 SELECT cycles.
    push_beat(0, '0);
    tick();
    act_r[0]  = '0;
    beat_r[0] = 1'b1;
    tick();
    beat_r[0] = 1'b0;
    n = 0;
    while (!rdy[0] && n < 30) begin
      tick();
      n++;
    end
    check("dut0 empty-mask select cycles", n, NUM_BOXES + 1);
    drain(0, "empty mask");

    for (int i = 0; i < 6; i++) begin
      m = NUM_BOXES'($urandom_range(0, 15));
      if (i == 2) begin
        m         = m | 4'b0001;
        inj_en[0] = 1'b1;
        exp_ovr[0] = 1'b1;
      end
      issue_beat(0, m);
      drain(0, "random beat");
      inj_en[0] = 1'b0;
      check_ovr(0);
    end

    // songDone raised mid-draw waits for WAIT_SONG, then clears to START.
    issue_beat(0, 4'b0110);
    song_r[0] = 1'b1;
    push_clear(0);
    drain(0, "late songDone");
    song_r[0] = 1'b0;
    start_song(0);

    // songDone and beat together: songDone wins.
    push_clear(0);
    tick();
    act_r[0]  = 4'b1111;
    beat_r[0] = 1'b1;
    song_r[0] = 1'b1;
    tick();
    beat_r[0] = 1'b0;
    song_r[0] = 1'b0;
    drain(0, "song end");
    start_song(0);
    check_ovr(0);

    // ---- instance 1: full clear before every beat ----
    for (int i = 0; i < 4; i++) begin
      m = NUM_BOXES'($urandom_range(0, 15));
      if (i == 1) begin
        m          = m | 4'b1000;
        inj_en[1]  = 1'b1;
        exp_ovr[1] = 1'b1;
      end
      issue_beat(1, m);
      // A shapeDone during the clear must not move the box walk.
      stray_shape[1] = 1'b1;
      tick();
      stray_shape[1] = 1'b0;
      drain(1, "clear beat");
      inj_en[1] = 1'b0;
      check_ovr(1);
    end

    // songDone and beat together: clear exits to START, no box draws.
    push_clear(1);
    tick();
    act_r[1]  = 4'b1111;
    beat_r[1] = 1'b1;
    song_r[1] = 1'b1;
    tick();
    beat_r[1] = 1'b0;
    song_r[1] = 1'b0;
    drain(1, "song end");
    start_song(1);

    // Reset during the sixth write restarts the clear from address 0.
    issue_beat(1, 4'b0101);
    k = 0;
    while (!(wr[1] === 1'b1 && gc[1] == GW'(5)) && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("dut1 reached sixth write", int'(k < 200), 1);
    reset_r[1] = 1'b1;
    exp_ovr[1] = 1'b0;
    tick();
    tick();
    check("dut1 mid-clear reset gridCounter", int'(gc[1]), 0);
    check("dut1 mid-clear reset boxIndex", int'(bi[1]), 0);
    check_ovr(1);
    exp_q[1].delete();
    push_clear(1);
    reset_r[1] = 1'b0;
    drain(1, "post-reset clear");
    start_song(1);
    issue_beat(1, 4'b0011);
    drain(1, "post-reset beat");
    check_ovr(1);

    repeat (10) tick();
    check("dut0 queue empty at end", exp_q[0].size(), 0);
    check("dut1 queue empty at end", exp_q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
